mult_arbiter: RTL and testbench

MULT_ARBITER -- requirements
Module: mult_arbiter

---
 rtl/mult_arbiter_if.sv | 32 +++
 rtl/mult_arbiter.sv | 97 +++++++++
 tb/tb_mult_arbiter.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_arbiter_if.sv
// Bundle of the two requester ports and the shared-multiplier port seen by
// mult_arbiter. The arbiter uses the slave view; the surrounding system
// (requesters plus the multiplier) uses the master view.
interface mult_arbiter_if;
   logic       req0;
   logic       req1;
   logic [3:0] a0;
   logic [3:0] b0;
   logic [3:0] a1;
   logic [3:0] b1;
   logic       gnt0;
   logic       gnt1;
   logic       ack0;
   logic       ack1;
   logic [7:0] p_out;
   logic       err;
   logic       mult_go;
   logic [3:0] mult_a;
   logic [3:0] mult_b;
   logic       mult_done;
   logic [7:0] mult_p;

   modport slave (
      input  req0, req1, a0, b0, a1, b1, mult_done, mult_p,
      output gnt0, gnt1, ack0, ack1, p_out, err, mult_go, mult_a, mult_b
   );

   modport master (
      output req0, req1, a0, b0, a1, b1, mult_done, mult_p,
      input  gnt0, gnt1, ack0, ack1, p_out, err, mult_go, mult_a, mult_b
   );
endinterface

// File: rtl/mult_arbiter.sv
// Two-requester round-robin arbiter in front of a shared 4x4 sequential
// multiplier. One transaction at a time: IDLE picks a winner and latches its
// operands, START pulses mult_go, WAIT waits for mult_done (or times out),
// RESP pulses the winner's ack with the product (or err on timeout).
module mult_arbiter #(
   parameter int unsigned TIMEOUT = 16
) (
   input logic           clk,
   input logic           clr,
   mult_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

   // Last WAIT cycle before an unanswered request is aborted.
   localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

   state_t     state_q;
   logic       win_q;    // requester owning the current transaction
   logic       last_q;   // requester served most recently (tie breaker)
   logic [7:0] timer_q;
   logic [7:0] p_q;
   logic       err_q;
   logic [3:0] ma_q;
   logic [3:0] mb_q;
   logic       win_d;

   // Winner for a request seen in IDLE: a tie goes to whoever was not served last.
   always_comb begin
      win_d = 1'b0;
      if (bus.req0 && bus.req1) begin
         win_d = ~last_q;
      end else if (bus.req1) begin
         win_d = 1'b1;
      end
   end

   // Transaction FSM with its datapath registers (operands, timer, result).
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= IDLE;
         win_q   <= 1'b0;
         last_q  <= 1'b1;
         timer_q <= 8'd0;
         p_q     <= 8'd0;
         err_q   <= 1'b0;
         ma_q    <= 4'd0;
         mb_q    <= 4'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.req0 || bus.req1) begin
                  win_q   <= win_d;
                  ma_q    <= win_d ? bus.a1 : bus.a0;
                  mb_q    <= win_d ? bus.b1 : bus.b0;
                  state_q <= START;
               end
            end
            START: begin
               timer_q <= 8'd0;
               state_q <= WAIT;
            end
            WAIT: begin
               // A completion on the last timer cycle still counts as success.
               if (bus.mult_done) begin
                  p_q     <= bus.mult_p;
                  err_q   <= 1'b0;
                  state_q <= RESP;
               end else if (timer_q == TLAST) begin
                  p_q     <= 8'd0;
                  err_q   <= 1'b1;
                  state_q <= RESP;
               end else begin
                  timer_q <= timer_q + 8'd1;
               end
            end
            RESP: begin
               last_q  <= win_q;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Control outputs are pure decodes of the registered state and winner.
   assign bus.gnt0    = (state_q != IDLE) && !win_q;
   assign bus.gnt1    = (state_q != IDLE) &&  win_q;
   assign bus.ack0    = (state_q == RESP) && !win_q;
   assign bus.ack1    = (state_q == RESP) &&  win_q;
   assign bus.mult_go = (state_q == START);
   assign bus.mult_a  = ma_q;
   assign bus.mult_b  = mb_q;
   assign bus.p_out   = p_q;
   assign bus.err     = err_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: directed requester stimulus, a behavioural
// multiplier, and a scoreboard monitor that checks every ack.
module tb_mult_arbiter;

   logic clk = 1'b0;
   logic clr;
   always #5 clk = ~clk;

   mult_arbiter_if bus ();

   mult_arbiter #(.TIMEOUT(16)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   typedef struct {
      int         who;
      logic [7:0] p;
      logic       err;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   bit   g1_seen = 1'b0;

   // Multiplier model controls
   bit         md_en   = 1'b1;
   int         md_lat  = 4;
   bit         md_ovr  = 1'b0;
   logic [7:0] md_pval = 8'h00;
   int         md_go_cyc   = 0;
   int         md_done_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Behavioural multiplier: done md_lat cycles after mult_go, unless disabled.
   initial begin
      logic [7:0] pr;
      bus.mult_done = 1'b0;
      bus.mult_p    = 8'h00;
      forever begin
         @(negedge clk);
         if (bus.mult_go === 1'b1) begin
            md_go_cyc = cyc;
            pr = 8'(bus.mult_a) * 8'(bus.mult_b);
            if (md_ovr) pr = md_pval;
            if (md_en) begin
               repeat (md_lat) @(negedge clk);
               bus.mult_done = 1'b1;
               bus.mult_p    = pr;
               md_done_cyc   = cyc;
               @(negedge clk);
               bus.mult_done = 1'b0;
               bus.mult_p    = 8'h00;
            end
         end
      end
   end

   // Scoreboard monitor: every ack must match the oldest expected response.
   always @(negedge clk) begin
      exp_t e;
      if (bus.gnt1 === 1'b1) g1_seen = 1'b1;
      if (bus.ack0 === 1'b1 || bus.ack1 === 1'b1) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_ack: got ack0=%0b ack1=%0b expected no ack", bus.ack0, bus.ack1);
         end else begin
            e = sb.pop_front();
            chk("ack_who", {30'd0, bus.ack1, bus.ack0}, (e.who == 1) ? 32'd2 : 32'd1);
            chk("ack_gnt", {30'd0, bus.gnt1, bus.gnt0}, (e.who == 1) ? 32'd2 : 32'd1);
            chk("ack_p",   {24'd0, bus.p_out}, {24'd0, e.p});
            chk("ack_err", {31'd0, bus.err}, {31'd0, e.err});
         end
      end
   end

   task automatic wait_ack(input int who, output int acyc);
      bit got;
      got  = 1'b0;
      acyc = -1;
      for (int i = 0; i < 60 && !got; i++) begin
         @(negedge clk);
         if ((who == 0 && bus.ack0 === 1'b1) || (who == 1 && bus.ack1 === 1'b1)) begin
            got  = 1'b1;
            acyc = cyc;
         end
      end
      if (!got) begin
         total++;
         bad++;
         $display("FAIL ack_wait: got no ack for requester %0d within 60 cycles, expected one", who);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_gnt"},  {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
      chk({tag, "_ack"},  {30'd0, bus.ack1, bus.ack0}, 32'd0);
      chk({tag, "_go"},   {31'd0, bus.mult_go}, 32'd0);
      chk({tag, "_err"},  {31'd0, bus.err}, 32'd0);
      chk({tag, "_p"},    {24'd0, bus.p_out}, 32'd0);
      chk({tag, "_ma"},   {28'd0, bus.mult_a}, 32'd0);
      chk({tag, "_mb"},   {28'd0, bus.mult_b}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no end of test by time limit, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int ac;
      bit seen;
      bit busy;
      clr = 1'b1;
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      bus.a0 = 4'd0; bus.b0 = 4'd0; bus.a1 = 4'd0; bus.b1 = 4'd0;
      repeat (2) @(negedge clk);
      chk_all_zero("reset");
      clr = 1'b0;

      // Single request from requester 0: 3*5
      @(negedge clk);
      g1_seen = 1'b0;
      bus.a0 = 4'd3; bus.b0 = 4'd5; bus.req0 = 1'b1;
      sb.push_back('{0, 8'd15, 1'b0});
      @(negedge clk);
      chk("single_go",  {31'd0, bus.mult_go}, 32'd1);
      chk("single_ma",  {28'd0, bus.mult_a}, 32'd3);
      chk("single_mb",  {28'd0, bus.mult_b}, 32'd5);
      chk("single_gnt", {30'd0, bus.gnt1, bus.gnt0}, 32'd1);
      wait_ack(0, ac);
      bus.req0 = 1'b0;
      chk("single_ack_lat", ac, md_done_cyc + 1);
      @(negedge clk);
      chk("single_ack_pulse", {30'd0, bus.ack1, bus.ack0}, 32'd0);
      chk("single_p_hold", {24'd0, bus.p_out}, 32'd15);
      chk("single_gnt1_never", {31'd0, g1_seen}, 32'd0);

      // Tie right after reset: requester 0 first, then requester 1
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      bus.a0 = 4'd2; bus.b0 = 4'd7; bus.a1 = 4'd15; bus.b1 = 4'd15;
      bus.req0 = 1'b1; bus.req1 = 1'b1;
      sb.push_back('{0, 8'd14, 1'b0});
      sb.push_back('{1, 8'd225, 1'b0});
      wait_ack(0, ac);
      bus.req0 = 1'b0;
      chk("tie_ack0_lat", ac, md_done_cyc + 1);
      wait_ack(1, ac);
      bus.req1 = 1'b0;
      chk("tie_ack1_lat", ac, md_done_cyc + 1);

      // Fairness: both requests held for six transactions
      @(negedge clk);
      bus.a0 = 4'd4; bus.b0 = 4'd6; bus.a1 = 4'd9; bus.b1 = 4'd13;
      bus.req0 = 1'b1; bus.req1 = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (i % 2 == 0) sb.push_back('{0, 8'd24, 1'b0});
         else            sb.push_back('{1, 8'd117, 1'b0});
      end
      for (int i = 0; i < 6; i++) begin
         wait_ack(i % 2, ac);
         chk("fair_ack_lat", ac, md_done_cyc + 1);
      end
      bus.req0 = 1'b0; bus.req1 = 1'b0;

      // Timeout: multiplier never answers
      md_en = 1'b0;
      @(negedge clk);
      bus.a0 = 4'd1; bus.b0 = 4'd1; bus.req0 = 1'b1;
      sb.push_back('{0, 8'd0, 1'b1});
      wait_ack(0, ac);
      bus.req0 = 1'b0;
      chk("timeout_lat", ac, md_go_cyc + 17);
      @(negedge clk);
      chk("timeout_idle_gnt", {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
      md_en = 1'b1;

      // Boundary: done on the final timer cycle wins over the timeout
      md_lat = 16; md_ovr = 1'b1; md_pval = 8'h51;
      @(negedge clk);
      bus.a1 = 4'd2; bus.b1 = 4'd3; bus.req1 = 1'b1;
      sb.push_back('{1, 8'h51, 1'b0});
      wait_ack(1, ac);
      bus.req1 = 1'b0;
      chk("bound_lat_go", ac, md_go_cyc + 17);
      chk("bound_lat_done", ac, md_done_cyc + 1);
      md_ovr = 1'b0; md_lat = 6;

      // Reset during WAIT, then a stray mult_done arrives
      @(negedge clk);
      bus.a0 = 4'd5; bus.b0 = 4'd5; bus.req0 = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (bus.mult_go === 1'b1) seen = 1'b1;
      end
      chk("rst_go_seen", {31'd0, seen}, 32'd1);
      repeat (2) @(negedge clk);
      clr = 1'b1; bus.req0 = 1'b0;
      @(negedge clk);
      clr = 1'b0;
      chk_all_zero("midrst");
      busy = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0 || bus.mult_go !== 1'b0 ||
             bus.ack0 !== 1'b0 || bus.ack1 !== 1'b0) busy = 1'b1;
      end
      chk("midrst_quiet", {31'd0, busy}, 32'd0);
      md_lat = 4;
      bus.a0 = 4'd1; bus.b0 = 4'd7; bus.a1 = 4'd3; bus.b1 = 4'd3;
      bus.req0 = 1'b1; bus.req1 = 1'b1;
      sb.push_back('{0, 8'd7, 1'b0});
      sb.push_back('{1, 8'd9, 1'b0});
      wait_ack(0, ac);
      bus.req0 = 1'b0;
      wait_ack(1, ac);
      bus.req1 = 1'b0;

      repeat (3) @(negedge clk);
      chk("sb_empty", sb.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
